// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry direction counters and saturating statistics.
// BTB_HYSTERESIS_EN selects 2-bit saturating counters; otherwise each entry keeps a 1-bit direction.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int STAT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [31:0]       fetch_pc,
   output logic              pred_taken,
   output logic [31:0]       pred_target,
   input  logic              upd_en,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic [31:0]       upd_target,
   input  logic              upd_is_jump,
   input  logic              upd_pred_taken,
   input  logic [31:0]       upd_pred_target,
   input  logic              flush_all,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_updates,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [31:0]       tgt_q   [ENTRIES];
   logic [1:0]        ctr_q   [ENTRIES];

   logic              mispredict_q, mispredict_d;
   logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
   logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

   logic [IDX_W-1:0]  fetch_idx, upd_idx;
   logic [TAG_W-1:0]  fetch_tag, upd_tag;
   logic              fetch_hit, upd_hit, upd_acc, upd_mp;

   logic              ent_we;
   logic [31:0]       ent_tgt_d;
   logic [1:0]        ent_ctr_d;

   logic              unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign fetch_tag = fetch_pc[31:IDX_W+2];
   assign upd_idx   = upd_pc[IDX_W+1:2];
   assign upd_tag   = upd_pc[31:IDX_W+2];

   assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
   assign pred_target = pred_taken ? tgt_q[fetch_idx] : fetch_pc + 32'd4;

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   // flush_all wins over a same-cycle update, which is then neither applied nor counted
   assign upd_acc = upd_en && !flush_all;
   assign upd_mp  = (upd_pred_taken != upd_taken) ||
                    (upd_taken && (upd_pred_target != upd_target));

`ifdef BTB_HYSTERESIS_EN
   function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
      if (up)
         return (c == 2'b11) ? c : c + 2'd1;
      else
         return (c == 2'b00) ? c : c - 2'd1;
   endfunction
`endif

   always_comb begin
      ent_we    = 1'b0;
      ent_tgt_d = tgt_q[upd_idx];
      ent_ctr_d = ctr_q[upd_idx];
      if (upd_acc) begin
         if (upd_hit) begin
            ent_we = 1'b1;
            if (upd_is_jump) begin
`ifdef BTB_HYSTERESIS_EN
               ent_ctr_d = 2'b11;
`else
               ent_ctr_d = 2'b10;
`endif
               ent_tgt_d = upd_target;
            end else begin
`ifdef BTB_HYSTERESIS_EN
               ent_ctr_d = ctr_step(ctr_q[upd_idx], upd_taken);
`else
               ent_ctr_d = {upd_taken, 1'b0};
`endif
               if (upd_taken)
                  ent_tgt_d = upd_target;
            end
         end else if (upd_taken) begin
            // allocation replaces whatever alias occupied the slot
            ent_we    = 1'b1;
            ent_tgt_d = upd_target;
`ifdef BTB_HYSTERESIS_EN
            ent_ctr_d = upd_is_jump ? 2'b11 : 2'b10;
`else
            ent_ctr_d = 2'b10;
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= 2'b00;
         end
      end else if (flush_all) begin
         for (int i = 0; i < ENTRIES; i++)
            valid_q[i] <= 1'b0;
      end else if (ent_we) begin
         valid_q[upd_idx] <= 1'b1;
         tag_q[upd_idx]   <= upd_tag;
         tgt_q[upd_idx]   <= ent_tgt_d;
         ctr_q[upd_idx]   <= ent_ctr_d;
      end
   end

   always_comb begin
      mispredict_d = upd_acc && upd_mp;
      stat_upd_d   = stat_upd_q;
      stat_mis_d   = stat_mis_q;
      if (upd_acc && (stat_upd_q != '1))
         stat_upd_d = stat_upd_q + STAT_W'(1);
      if (upd_acc && upd_mp && (stat_mis_q != '1))
         stat_mis_d = stat_mis_q + STAT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         mispredict_q <= 1'b0;
         stat_upd_q   <= '0;
         stat_mis_q   <= '0;
      end else begin
         mispredict_q <= mispredict_d;
         stat_upd_q   <= stat_upd_d;
         stat_mis_q   <= stat_mis_d;
      end
   end

   assign mispredict       = mispredict_q;
   assign stat_updates     = stat_upd_q;
   assign stat_mispredicts = stat_mis_q;

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer with saturating direction counters, used in the fetch stage of the pipelined datapath to predict next PC for branches and jumps. Fetch presents the current PC and gets a combinational taken/target prediction. The resolving pipeline stage writes back the actual outcome one instruction at a time. Update and mispredict statistics are kept for performance analysis.

## Interface
- ENTRIES, 16: number of entries; power of two, 4..1024. IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.
- STAT_W, 16: width of statistics counters.
- CLK  input  1  clock, all state updates on rising edge.
- nRST  input  1  synchronous reset, active-high: asserted when 1, sampled on rising CLK.
- fetch_pc  input  32  PC being fetched.
- pred_taken  output  1  predict taken for fetch_pc.
- pred_target  output  32  predicted next PC.
- upd_en  input  1  one-cycle pulse: a branch/jump resolved this cycle.
- upd_pc  input  32  PC of resolved instruction.
- upd_taken  input  1  actual direction.
- upd_target  input  32  actual taken target.
- upd_is_jump  input  1  unconditional (j/jal/jr).
- upd_pred_taken  input  1  prediction carried down the pipe with this instruction.
- upd_pred_target  input  32  predicted target carried down the pipe.
- flush_all  input  1  invalidate every entry.
- mispredict  output  1  registered: previous cycle's update was a mispredict.
- stat_updates  output  STAT_W  count of accepted updates.
- stat_mispredicts  output  STAT_W  count of mispredicts.

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Per entry: valid, tag, target[31:0], counter ctr[1:0].
- Lookup (combinational):
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target : fetch_pc + 4 (mod 2^32).
- Update when upd_en=1 and flush_all=0:
  - Hit on upd_pc, conditional branch: ctr saturating +1 if taken, -1 if not (clamped 00..11). Target overwritten only if taken.
  - Hit, jump: ctr forced 11 and target written.
  - Miss and upd_taken=1: allocate, overwriting any alias. valid=1, tag, target written; ctr=11 if upd_is_jump, else 10 (weakly taken).
  - Miss and upd_taken=0: no allocation.
- Mispredict condition: (upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target). Evaluated only when upd_en=1.
- Statistics:
  - stat_updates increments on every accepted update.
  - stat_mispredicts increments when the mispredict condition holds.
  - Both saturate at all-ones.
  - Neither is cleared by flush_all.
- flush_all clears all valid bits. It has priority over a same-cycle upd_en; that update is dropped and not counted.

## Timing
- Lookup latency zero (combinational from fetch_pc and state).
- Update visible to lookup the cycle after upd_en. A same-cycle lookup of the updated index sees old contents.
- mispredict asserted for exactly one cycle, the cycle after the qualifying upd_en; otherwise 0.
- Reset (nRST=1 at edge): all valid=0, ctr=00, tag/target=0, stats=0, mispredict=0. While no entry is valid: pred_taken=0, pred_target=fetch_pc+4.
- Reset mid-operation overrides upd_en and flush_all in that cycle.
- Back-to-back upd_en every cycle is supported, including repeated updates to the same index.

## Configuration
- BTB_HYSTERESIS_EN defined: 2-bit saturating counters as above.
- BTB_HYSTERESIS_EN undefined: 1-bit counter (ctr[1] only).
  - Every update to an entry sets it to upd_taken (1 for jumps).
  - Allocation sets it to 1.
  - pred_taken = hit && ctr[1].
  - All other behaviour is identical.

## Test plan
ENTRIES=16 unless noted.
- Reset, fetch_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044; stats=0, mispredict=0.
- Update 0x100: taken, target 0x200, upd_pred_taken=0 -> next cycle lookup 0x100 gives pred_taken=1, pred_target=0x200; mispredict pulses 1 cycle; stat_mispredicts=1.
- Hysteresis (macro defined): update 0x100 taken again (ctr 11), then not-taken once -> pred_taken still 1. Without the macro -> pred_taken=0 after the not-taken.
- Alias: lookup 0x140 (same index as 0x100, different tag) -> miss, target 0x144. Update 0x140 taken to 0x300 -> lookup 0x100 misses and 0x140 predicts 0x300. Not-taken update of 0x180 (miss) -> no allocation.
- flush_all and upd_en (0x100 taken) in the same cycle -> next cycle 0x100 misses; stat_updates unchanged.
- STAT_W=4, 20 mispredicting updates -> both stat counters hold at 0xF.
